alu_reservation_station: RTL and testbench

Integer-ALU reservation station on the receive side of the reorder buffer's dispatch/broadcast protocol.
- Accepts one dispatched instruction per cycle when the reorder buffer asserts its ALU-load strobe.
- Holds the instruction until both operands are valid, snooping the reorder buffer's per-tag broadcast bus for missing operands.
- Computes the result and returns it, tagged with the instruction's ROB tag, on a per-entry result array for writeback into the reorder buffer.
- Back-pressures dispatch through `stall`.

---
 rtl/rv32i_types.sv | 29 ++
 rtl/rs_alu.sv | 36 +++
 rtl/alu_reservation_station.sv | 107 ++++++++++
 tb/tb_alu_reservation_station.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I types for the ALU reservation station slice.
// No latency: types and constants only.
// No flow control here; rs_entry_t holds the per-entry state of the station.
package rv32i_types;

  localparam int XLEN  = 32;
  localparam int TAG_W = 4;

  typedef enum logic [3:0] {
    rs_add, rs_sub, rs_sll, rs_slt, rs_sltu,
    rs_xor, rs_srl, rs_sra, rs_or, rs_and
  } rs_aluop_t;

  // Operand / result slot: when rdy=0, tag names the ROB entry that will produce data.
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             rdy;
    logic [XLEN-1:0]  data;
  } sal_t;

  typedef struct packed {
    logic             busy;
    rs_aluop_t        op;
    logic [TAG_W-1:0] rd_tag;
    sal_t             src1;
    sal_t             src2;
  } rs_entry_t;

endpackage

// File: rtl/rs_alu.sv
// Combinational integer ALU used by one reservation-station entry.
// Latency: zero cycles (pure combinational).
// No backpressure: result tracks op/a/b continuously.
// Ports: op (operation), a/b (operands), result (width bits, mod 2^width).
module rs_alu
  import rv32i_types::*;
#(
  parameter int width = 32
) (
  input  rs_aluop_t          op,
  input  logic [width-1:0]   a,
  input  logic [width-1:0]   b,
  output logic [width-1:0]   result
);

  logic [4:0] shamt;
  assign shamt = b[4:0];

  always_comb begin
    result = '0;
    unique case (op)
      rs_add:  result = a + b;
      rs_sub:  result = a - b;
      rs_sll:  result = a << shamt;
      rs_slt:  result = {{(width-1){1'b0}}, $signed(a) < $signed(b)};
      rs_sltu: result = {{(width-1){1'b0}}, a < b};
      rs_xor:  result = a ^ b;
      rs_srl:  result = a >> shamt;
      rs_sra:  result = $unsigned($signed(a) >>> shamt);
      rs_or:   result = a | b;
      rs_and:  result = a & b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_reservation_station.sv
// Integer-ALU reservation station: holds dispatched ops until both operands are valid, then issues.
// Latency: load at edge k -> result pulse after edge k+1; broadcast in cycle c -> result after edge c+1.
// Backpressure: stall (combinational) is high while every entry is busy; load is ignored then.
// Ports: clk, rst (async, active-high), load/op/rd_tag/src1/src2 (dispatch), rob_broadcast_bus
// (per-tag completed results), alu_rs_o (per-entry one-cycle result pulse), stall.
// Option: define ALU_RS_DISPATCH_BYPASS_EN to capture a matching broadcast in the load cycle itself.
module alu_reservation_station
  import rv32i_types::*;
#(
  parameter int size     = 8,
  parameter int rob_size = 8,
  parameter int width    = 32
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      load,
  input  rs_aluop_t op,
  input  logic [3:0] rd_tag,
  input  sal_t      src1,
  input  sal_t      src2,
  input  sal_t      rob_broadcast_bus [rob_size],
  output sal_t      alu_rs_o [size],
  output logic      stall
);

  localparam int ROB_IW  = (rob_size > 1) ? $clog2(rob_size) : 1;
  localparam int SIZE_IW = (size > 1) ? $clog2(size) : 1;

  rs_entry_t          ent [size];
  logic [size-1:0]    busy_vec;
  logic [size-1:0]    ready_vec;
  logic [width-1:0]   result [size];
  logic               alloc_vld;
  logic [SIZE_IW-1:0] alloc_idx;

  // Broadcast slots are indexed directly by tag; out-of-range tags never match.
  function automatic sal_t snoop(sal_t s);
    sal_t r;
    r = s;
    if (!s.rdy && (int'(s.tag) < rob_size) && rob_broadcast_bus[s.tag[ROB_IW-1:0]].rdy) begin
      r.rdy  = 1'b1;
      r.data = rob_broadcast_bus[s.tag[ROB_IW-1:0]].data;
    end
    return r;
  endfunction

  function automatic sal_t load_src(sal_t s);
`ifdef ALU_RS_DISPATCH_BYPASS_EN
    return snoop(s);
`else
    // Slots persist until commit, so a waiting operand is picked up next cycle.
    return s;
`endif
  endfunction

  for (genvar g = 0; g < size; g++) begin : g_entry
    assign busy_vec[g]  = ent[g].busy;
    assign ready_vec[g] = ent[g].busy & ent[g].src1.rdy & ent[g].src2.rdy;

    rs_alu #(.width(width)) u_alu (
      .op     (ent[g].op),
      .a      (ent[g].src1.data),
      .b      (ent[g].src2.data),
      .result (result[g])
    );
  end

  assign stall = &busy_vec;

  // Lowest free entry; scanning downward lets the lowest index win.
  always_comb begin
    alloc_vld = 1'b0;
    alloc_idx = '0;
    for (int i = size - 1; i >= 0; i--) begin
      if (!ent[i].busy) begin
        alloc_vld = 1'b1;
        alloc_idx = SIZE_IW'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < size; i++) begin
        ent[i]      <= '0;
        alu_rs_o[i] <= '0;
      end
    end else begin
      for (int i = 0; i < size; i++) begin
        // Result is a single-cycle pulse; tag/data simply hold their last value.
        alu_rs_o[i].rdy <= 1'b0;
        if (ready_vec[i]) begin
          alu_rs_o[i] <= '{tag: ent[i].rd_tag, rdy: 1'b1, data: result[i]};
          ent[i].busy <= 1'b0;
        end else if (ent[i].busy) begin
          ent[i].src1 <= snoop(ent[i].src1);
          ent[i].src2 <= snoop(ent[i].src2);
        end else if (load && !stall && alloc_vld && (alloc_idx == SIZE_IW'(i))) begin
          // stall uses the pre-edge busy state, so entries freed this edge are not reused yet.
          ent[i] <= '{busy: 1'b1, op: op, rd_tag: rd_tag,
                      src1: load_src(src1), src2: load_src(src2)};
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_reservation_station.sv
module tb_alu_reservation_station;
  import rv32i_types::*;

  localparam int SIZE = 8;
  localparam int ROB  = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  rs_aluop_t  op;
  logic [3:0] rd_tag;
  sal_t       src1, src2;
  sal_t       bus  [ROB];
  sal_t       outv [SIZE];
  logic       stall;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_reservation_station #(.size(SIZE), .rob_size(ROB), .width(32)) dut (
    .clk(clk), .rst(rst), .load(load), .op(op), .rd_tag(rd_tag),
    .src1(src1), .src2(src2), .rob_broadcast_bus(bus),
    .alu_rs_o(outv), .stall(stall)
  );

  // ---------------- reference model ----------------
  typedef struct {
    bit         busy;
    rs_aluop_t  op;
    logic [3:0] rd;
    sal_t       s1;
    sal_t       s2;
  } m_ent_t;

  m_ent_t m     [SIZE];
  sal_t   m_out [SIZE];

  function automatic logic [31:0] ref_calc(rs_aluop_t o, logic [31:0] a, logic [31:0] b);
    int sh;
    sh = int'(b[4:0]);
    case (o)
      rs_add:  return a + b;
      rs_sub:  return a + ~b + 32'd1;
      rs_sll:  return a << sh;
      rs_srl:  return a >> sh;
      rs_sra:  return a[31] ? ~((~a) >> sh) : (a >> sh);
      rs_slt:  return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      rs_sltu: return (a < b) ? 32'd1 : 32'd0;
      rs_xor:  return a ^ b;
      rs_or:   return a | b;
      rs_and:  return a & b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic sal_t resolve(sal_t s);
    sal_t r;
    r = s;
    if (!s.rdy && s.tag < ROB) begin
      if (bus[s.tag[2:0]].rdy) begin
        r.rdy  = 1'b1;
        r.data = bus[s.tag[2:0]].data;
      end
    end
    return r;
  endfunction

  function automatic sal_t at_load(sal_t s);
`ifdef ALU_RS_DISPATCH_BYPASS_EN
    return resolve(s);
`else
    return s;
`endif
  endfunction

  function automatic bit m_full();
    for (int i = 0; i < SIZE; i++) if (!m[i].busy) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < SIZE; i++) begin
      m[i].busy = 1'b0;
      m[i].s1   = '0;
      m[i].s2   = '0;
      m_out[i]  = '0;
    end
  endtask

  task automatic model_edge();
    m_ent_t nx [SIZE];
    sal_t   no [SIZE];
    int     free_i;
    bit     full;
    full   = m_full();
    free_i = -1;
    for (int i = SIZE - 1; i >= 0; i--) if (!m[i].busy) free_i = i;
    nx = m;
    no = m_out;
    for (int i = 0; i < SIZE; i++) begin
      no[i].rdy = 1'b0;
      if (m[i].busy) begin
        if (m[i].s1.rdy && m[i].s2.rdy) begin
          no[i] = '{tag: m[i].rd, rdy: 1'b1, data: ref_calc(m[i].op, m[i].s1.data, m[i].s2.data)};
          nx[i].busy = 1'b0;
        end else begin
          nx[i].s1 = resolve(m[i].s1);
          nx[i].s2 = resolve(m[i].s2);
        end
      end
    end
    if (load && !full && free_i >= 0)
      nx[free_i] = '{busy: 1'b1, op: op, rd: rd_tag, s1: at_load(src1), s2: at_load(src2)};
    m     = nx;
    m_out = no;
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(string name, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", name, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("stall", {63'd0, stall}, {63'd0, m_full()});
    for (int i = 0; i < SIZE; i++) begin
      chk($sformatf("out%0d.rdy", i), {63'd0, outv[i].rdy}, {63'd0, m_out[i].rdy});
      if (m_out[i].rdy)
        chk($sformatf("out%0d.tag_data", i), {28'd0, outv[i].tag, outv[i].data},
            {28'd0, m_out[i].tag, m_out[i].data});
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) model_edge();
    #1;
    check_all();
  endtask

  task automatic idle();
    load   = 1'b0;
    op     = rs_add;
    rd_tag = 4'd0;
    src1   = '0;
    src2   = '0;
  endtask

  task automatic clear_bus();
    for (int i = 0; i < ROB; i++) bus[i] = '0;
  endtask

  task automatic do_one(string t, rs_aluop_t o, logic [31:0] a, logic [31:0] b,
                        logic [3:0] rt, logic [31:0] exp_d);
    load = 1'b1; op = o; rd_tag = rt;
    src1 = '{tag: 4'd0, rdy: 1'b1, data: a};
    src2 = '{tag: 4'd0, rdy: 1'b1, data: b};
    step();
    idle();
    step();
    chk(t, {27'd0, outv[0].tag, outv[0].rdy, outv[0].data}, {27'd0, rt, 1'b1, exp_d});
    step();
    chk({t, "_pulse_end"}, {63'd0, outv[0].rdy}, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int exp_lat;
    rst = 1'b1;
    idle();
    clear_bus();
    model_reset();
    #1;
    chk("rst_stall", {63'd0, stall}, 64'd0);
    for (int i = 0; i < SIZE; i++)
      chk($sformatf("rst_out%0d", i), {27'd0, outv[i]}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Basic function and arithmetic corner cases.
    do_one("add_5_7", rs_add, 32'd5, 32'd7, 4'd3, 32'd12);
    do_one("sra_neg", rs_sra, 32'h8000_0000, 32'd4, 4'd1, 32'hF800_0000);
    do_one("sltu_1_max", rs_sltu, 32'd1, 32'hFFFF_FFFF, 4'd2, 32'd1);
    do_one("slt_1_m1", rs_slt, 32'd1, 32'hFFFF_FFFF, 4'd4, 32'd0);

    // src2 waits on tag 6, broadcast arrives later.
    load = 1'b1; op = rs_sub; rd_tag = 4'd5;
    src1 = '{tag: 4'd0, rdy: 1'b1, data: 32'd0};
    src2 = '{tag: 4'd6, rdy: 1'b0, data: 32'd0};
    step();
    idle();
    step();
    chk("sub_waiting", {63'd0, outv[0].rdy}, 64'd0);
    bus[6] = '{tag: 4'd6, rdy: 1'b1, data: 32'd1};
    step();
    chk("sub_captured", {63'd0, outv[0].rdy}, 64'd0);
    step();
    chk("sub_result", {27'd0, outv[0].tag, outv[0].rdy, outv[0].data},
        {27'd0, 4'd5, 1'b1, 32'hFFFF_FFFF});
    clear_bus();
    step();

    // Load in the same cycle as the producer's broadcast.
    bus[6] = '{tag: 4'd6, rdy: 1'b1, data: 32'd1};
    load = 1'b1; op = rs_sub; rd_tag = 4'd7;
    src1 = '{tag: 4'd0, rdy: 1'b1, data: 32'd0};
    src2 = '{tag: 4'd6, rdy: 1'b0, data: 32'd0};
    step();
    idle();
    lat = 1;
    while (!outv[0].rdy && lat < 6) begin
      step();
      lat++;
    end
`ifdef ALU_RS_DISPATCH_BYPASS_EN
    exp_lat = 2;
`else
    exp_lat = 3;
`endif
    chk("bypass_latency", 64'(lat), 64'(exp_lat));
    chk("bypass_result", {32'd0, outv[0].data}, {32'd0, 32'hFFFF_FFFF});
    clear_bus();
    step();

    // Fill all entries, each waiting on its own tag.
    for (int i = 0; i < SIZE; i++) begin
      load = 1'b1; op = rs_add; rd_tag = 4'(i);
      src1 = '{tag: 4'(i), rdy: 1'b0, data: 32'd0};
      src2 = '{tag: 4'd0, rdy: 1'b1, data: 32'(i)};
      step();
    end
    idle();
    chk("full_stall", {63'd0, stall}, 64'd1);
    load = 1'b1; op = rs_add; rd_tag = 4'd9;
    src1 = '{tag: 4'd0, rdy: 1'b1, data: 32'd1};
    src2 = '{tag: 4'd0, rdy: 1'b1, data: 32'd1};
    step();
    idle();
    chk("full_refused_stall", {63'd0, stall}, 64'd1);
    step();
    bus[0] = '{tag: 4'd0, rdy: 1'b1, data: 32'd100};
    step();
    chk("full_stall_after_capture", {63'd0, stall}, 64'd1);
    step();
    chk("full_stall_after_issue", {63'd0, stall}, 64'd0);
    chk("full_first_result", {27'd0, outv[0].tag, outv[0].rdy, outv[0].data},
        {27'd0, 4'd0, 1'b1, 32'd100});
    for (int i = 0; i < ROB; i++) bus[i] = '{tag: 4'(i), rdy: 1'b1, data: 32'(i * 3)};
    repeat (3) step();
    clear_bus();
    step();

    // Two entries become ready together.
    load = 1'b1; op = rs_add; rd_tag = 4'd10;
    src1 = '{tag: 4'd2, rdy: 1'b0, data: 32'd0};
    src2 = '{tag: 4'd0, rdy: 1'b1, data: 32'd3};
    step();
    load = 1'b1; op = rs_or; rd_tag = 4'd11;
    src1 = '{tag: 4'd0, rdy: 1'b1, data: 32'd5};
    src2 = '{tag: 4'd2, rdy: 1'b0, data: 32'd0};
    step();
    idle();
    bus[2] = '{tag: 4'd2, rdy: 1'b1, data: 32'd9};
    step();
    step();
    chk("pair_out0", {27'd0, outv[0].tag, outv[0].rdy, outv[0].data}, {27'd0, 4'd10, 1'b1, 32'd12});
    chk("pair_out1", {27'd0, outv[1].tag, outv[1].rdy, outv[1].data}, {27'd0, 4'd11, 1'b1, 32'd13});
    clear_bus();
    step();

    // Randomised traffic against the model.
    for (int c = 0; c < 400; c++) begin
      load   = ($urandom_range(0, 2) != 0);
      op     = rs_aluop_t'(4'($urandom_range(0, 9)));
      rd_tag = 4'($urandom_range(0, 15));
      src1   = '{tag: 4'($urandom_range(0, 7)), rdy: 1'($urandom_range(0, 1)), data: $urandom};
      src2   = '{tag: 4'($urandom_range(0, 7)), rdy: 1'($urandom_range(0, 1)), data: $urandom};
      for (int t = 0; t < ROB; t++)
        if ($urandom_range(0, 3) == 0)
          bus[t] = '{tag: 4'(t), rdy: ($urandom_range(0, 2) == 0), data: $urandom};
      step();
    end
    idle();
    for (int i = 0; i < ROB; i++) bus[i] = '{tag: 4'(i), rdy: 1'b1, data: $urandom};
    repeat (3) step();
    clear_bus();
    step();
    chk("drained_stall", {63'd0, stall}, 64'd0);

    // Reset mid-operation: three waiting entries plus a live result pulse.
    for (int i = 0; i < 3; i++) begin
      load = 1'b1; op = rs_add; rd_tag = 4'(12 + i);
      src1 = '{tag: 4'(3 + i), rdy: 1'b0, data: 32'd0};
      src2 = '{tag: 4'd0, rdy: 1'b1, data: 32'd1};
      step();
    end
    load = 1'b1; op = rs_add; rd_tag = 4'd15;
    src1 = '{tag: 4'd0, rdy: 1'b1, data: 32'd2};
    src2 = '{tag: 4'd0, rdy: 1'b1, data: 32'd2};
    step();
    idle();
    step();
    chk("pre_reset_pulse", {63'd0, outv[3].rdy}, 64'd1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("async_rst_stall", {63'd0, stall}, 64'd0);
    for (int i = 0; i < SIZE; i++)
      chk($sformatf("async_rst_out%0d", i), {63'd0, outv[i].rdy}, 64'd0);
    for (int i = 3; i < 6; i++) bus[i] = '{tag: 4'(i), rdy: 1'b1, data: 32'd50};
    @(negedge clk);
    rst = 1'b0;
    repeat (4) step();
    clear_bus();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
